// File: rtl/multi_btn_debounce.sv
`default_nettype none
// ============================================================================
// multi_btn_debounce : N-channel button conditioner with a shared tick timer;
//                      emits debounced level plus press/release/long/repeat.
// Revision: 1.0 - initial release
// ============================================================================
module multi_btn_debounce #(
    parameter int N_BTN        = 5,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 1000,
    parameter int LONG_TICKS   = 100000,
    parameter int REPEAT_TICKS = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SC_W  = $clog2(STABLE_TICKS + 1);
    localparam int c_HC_W  = $clog2(LONG_TICKS + REPEAT_TICKS + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(STABLE_TICKS - 1);
    localparam logic [c_HC_W-1:0]  c_HC_LONG  = c_HC_W'(LONG_TICKS);
    localparam logic [c_HC_W-1:0]  c_HC_L_M1  = c_HC_W'(LONG_TICKS - 1);
    localparam logic [c_HC_W-1:0]  c_HC_R_M1  = c_HC_W'(LONG_TICKS + REPEAT_TICKS - 1);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_PRESS_W  = 2'd1;
    localparam logic [1:0] c_S_HELD     = 2'd2;
    localparam logic [1:0] c_S_RELEASE_W = 2'd3;

    logic [c_DIV_W-1:0] r_div;
    logic               r_tick;
    logic [N_BTN-1:0]   r_sync1;
    logic [N_BTN-1:0]   r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == c_DIV_LAST);
            r_div  <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_ch
            logic [1:0]        r_state;
            logic [c_SC_W-1:0] r_sc;
            logic [c_HC_W-1:0] r_hc;
            logic              r_level;
            logic              r_press;
            logic              r_release;
            logic              r_long;
            logic              r_repeat;
            logic              w_s;

            assign w_s = r_sync2[g];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state   <= c_S_IDLE;
                    r_sc      <= '0;
                    r_hc      <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                    r_repeat  <= 1'b0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                    r_repeat  <= 1'b0;
                    // An input change takes priority over a coincident tick.
                    case (r_state)
                        c_S_IDLE: begin
                            if (w_s) begin
                                r_state <= c_S_PRESS_W;
                                r_sc    <= '0;
                            end
                        end
                        c_S_PRESS_W: begin
                            if (!w_s) begin
                                r_state <= c_S_IDLE;
                                r_sc    <= '0;
                            end else if (r_tick) begin
                                if (r_sc == c_SC_LAST) begin
                                    r_state <= c_S_HELD;
                                    r_level <= 1'b1;
                                    r_press <= 1'b1;
                                    r_hc    <= '0;
                                end else begin
                                    r_sc <= r_sc + c_SC_W'(1);
                                end
                            end
                        end
                        c_S_HELD: begin
                            if (!w_s) begin
                                r_state <= c_S_RELEASE_W;
                                r_sc    <= '0;
                            end else if (r_tick) begin
                                if (r_hc == c_HC_L_M1) begin
                                    r_long <= 1'b1;
                                    r_hc   <= r_hc + c_HC_W'(1);
                                end else if (REPEAT_TICKS != 0 && r_hc == c_HC_R_M1) begin
                                    r_repeat <= 1'b1;
                                    r_hc     <= c_HC_LONG;
                                end else if (REPEAT_TICKS != 0 || r_hc != c_HC_LONG) begin
                                    r_hc <= r_hc + c_HC_W'(1);
                                end
                            end
                        end
                        default: begin
                            // Release bounce returns to HELD with the hold count intact.
                            if (w_s) begin
                                r_state <= c_S_HELD;
                            end else if (r_tick) begin
                                if (r_sc == c_SC_LAST) begin
                                    r_state   <= c_S_IDLE;
                                    r_level   <= 1'b0;
                                    r_release <= 1'b1;
                                end else begin
                                    r_sc <= r_sc + c_SC_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end

            assign o_level[g]   = r_level;
            assign o_press[g]   = r_press;
            assign o_release[g] = r_release;
            assign o_long[g]    = r_long;
            assign o_repeat[g]  = r_repeat;
        end
    endgenerate

endmodule
`default_nettype wire
